// File: rtl/eq_lock_detector_if.sv
// eq_lock_detector_if: sample/flag bundle between the comparator side and the lock detector.
// Latency: none, wires only. Backpressure: none, the detector accepts a valid sample every cycle.
// Signals: in_valid/aeqb/clear driven by master; locked, lock_pulse, unlock_pulse, run_len, err_cnt driven by slave.
interface eq_lock_detector_if #(
   parameter int CW = 8
);
   logic          in_valid;
   logic          aeqb;
   logic          clear;
   logic          locked;
   logic          lock_pulse;
   logic          unlock_pulse;
   logic [CW-1:0] run_len;
   logic [CW-1:0] err_cnt;

   modport master (
      output in_valid, aeqb, clear,
      input  locked, lock_pulse, unlock_pulse, run_len, err_cnt
   );

   modport slave (
      input  in_valid, aeqb, clear,
      output locked, lock_pulse, unlock_pulse, run_len, err_cnt
   );
endinterface

// File: rtl/eq_lock_detector.sv
// eq_lock_detector: declares lock after LOCK_CNT consecutive valid aeqb matches, drops it after UNLOCK_CNT consecutive valid mismatches.
// Latency: one cycle; every output is registered off the edge that takes the sample.
// Backpressure: none; a qualified sample is consumed on every cycle in_valid is high.
// Ports: i_clk, i_reset (async active-high), io_bus slave modport (in: in_valid, aeqb, clear; out: locked,
//        lock_pulse, unlock_pulse, run_len, err_cnt).
// Build option: define EQ_LOCK_ERRCNT_EN to build the mismatch-while-locked counter; otherwise err_cnt reads 0.
module eq_lock_detector #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int CW         = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   eq_lock_detector_if.slave io_bus
);
   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_LOCKED = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   localparam logic [CW:0]   LOCK_CMP   = (CW+1)'(LOCK_CNT);
   localparam logic [CW:0]   UNLOCK_CMP = (CW+1)'(UNLOCK_CNT);
   localparam logic [CW-1:0] SAT        = {CW{1'b1}};

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_locked;
   logic          w_locked_nxt;
   logic          r_lock_pulse;
   logic          w_lock_pulse_nxt;
   logic          r_unlock_pulse;
   logic          w_unlock_pulse_nxt;
   logic [CW-1:0] r_run_len;
   logic [CW-1:0] w_run_nxt;
   logic [CW-1:0] r_miss;
   logic [CW-1:0] w_miss_nxt;
   logic [CW:0]   w_run_inc;
   logic [CW:0]   w_miss_inc;
   logic [CW-1:0] w_run_sat;

   // One extra bit so the lock compare sees the true increment, not the saturated one.
   assign w_run_inc  = {1'b0, r_run_len} + (CW+1)'(1);
   assign w_run_sat  = w_run_inc[CW] ? SAT : w_run_inc[CW-1:0];
   assign w_miss_inc = {1'b0, r_miss} + (CW+1)'(1);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= S_SEARCH;
         r_locked       <= 1'b0;
         r_lock_pulse   <= 1'b0;
         r_unlock_pulse <= 1'b0;
         r_run_len      <= '0;
         r_miss         <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_locked       <= w_locked_nxt;
         r_lock_pulse   <= w_lock_pulse_nxt;
         r_unlock_pulse <= w_unlock_pulse_nxt;
         r_run_len      <= w_run_nxt;
         r_miss         <= w_miss_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_run_nxt          = r_run_len;
      w_miss_nxt         = r_miss;
      w_lock_pulse_nxt   = 1'b0;
      w_unlock_pulse_nxt = 1'b0;
      if (io_bus.clear) begin
         // Clear behaves like reset: no unlock_pulse even if we were locked.
         w_state_nxt = S_SEARCH;
         w_run_nxt   = '0;
         w_miss_nxt  = '0;
      end else if (io_bus.in_valid) begin
         case (r_state)
            S_SEARCH: begin
               if (io_bus.aeqb) begin
                  w_run_nxt = w_run_sat;
                  if (w_run_inc == LOCK_CMP) begin
                     w_state_nxt      = S_LOCKED;
                     w_lock_pulse_nxt = 1'b1;
                  end
               end else begin
                  w_run_nxt = '0;
               end
            end
            S_LOCKED: begin
               if (io_bus.aeqb) begin
                  w_run_nxt = w_run_sat;
               end else begin
                  w_run_nxt = '0;
                  if (UNLOCK_CNT == 1) begin
                     w_state_nxt        = S_SEARCH;
                     w_miss_nxt         = '0;
                     w_unlock_pulse_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_HOLD;
                     w_miss_nxt  = CW'(1);
                  end
               end
            end
            S_HOLD: begin
               if (io_bus.aeqb) begin
                  // A single match forgives the pending misses; run restarts at 1.
                  w_state_nxt = S_LOCKED;
                  w_miss_nxt  = '0;
                  w_run_nxt   = CW'(1);
               end else if (w_miss_inc == UNLOCK_CMP) begin
                  w_state_nxt        = S_SEARCH;
                  w_miss_nxt         = '0;
                  w_unlock_pulse_nxt = 1'b1;
               end else begin
                  w_miss_nxt = w_miss_inc[CW-1:0];
               end
            end
            default: begin
               w_state_nxt = S_SEARCH;
               w_run_nxt   = '0;
               w_miss_nxt  = '0;
            end
         endcase
      end
   end

   assign w_locked_nxt = (w_state_nxt != S_SEARCH);

   assign io_bus.locked       = r_locked;
   assign io_bus.lock_pulse   = r_lock_pulse;
   assign io_bus.unlock_pulse = r_unlock_pulse;
   assign io_bus.run_len      = r_run_len;

`ifdef EQ_LOCK_ERRCNT_EN
   logic [CW-1:0] r_err_cnt;
   logic [CW-1:0] w_err_nxt;

   // Every valid mismatch outside SEARCH is a mismatch taken while locked (LOCKED or HOLD).
   always_comb begin
      w_err_nxt = r_err_cnt;
      if (io_bus.clear) begin
         w_err_nxt = '0;
      end else if (io_bus.in_valid && !io_bus.aeqb && (r_state != S_SEARCH)) begin
         w_err_nxt = (r_err_cnt == SAT) ? SAT : r_err_cnt + CW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_err_cnt <= '0;
      end else begin
         r_err_cnt <= w_err_nxt;
      end
   end

   assign io_bus.err_cnt = r_err_cnt;
`else
   assign io_bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_eq_lock_detector.sv
// tb_eq_lock_detector: directed scenarios for eq_lock_detector with LOCK_CNT=4, UNLOCK_CNT=2, CW=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// err_cnt expectations follow EQ_LOCK_ERRCNT_EN: counted when defined, 0 otherwise.
module tb_eq_lock_detector;
`ifdef EQ_LOCK_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic       locked;
      logic       lock_pulse;
      logic       unlock_pulse;
      logic [7:0] run;
      logic [7:0] err;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   eq_lock_detector_if #(.CW(8)) bus ();

   eq_lock_detector #(
      .LOCK_CNT   (4),
      .UNLOCK_CNT (2),
      .CW         (8)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o = {bus.locked, bus.lock_pulse, bus.unlock_pulse, bus.run_len, bus.err_cnt};
      return o;
   endfunction

   function automatic obs_t ex(input bit l, input bit lp, input bit up, input int run, input int err);
      obs_t o;
      o.locked       = l;
      o.lock_pulse   = lp;
      o.unlock_pulse = up;
      o.run          = 8'(run);
      o.err          = ERR_EN ? 8'(err) : 8'd0;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("lk=%b lp=%b up=%b run=%0d err=%0d",
                       o.locked, o.lock_pulse, o.unlock_pulse, o.run, o.err);
   endfunction

   task automatic cyc(input logic v, input logic a);
      bus.in_valid = v;
      bus.aeqb     = a;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.aeqb     = 1'b0;
      bus.clear    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic lock_up();
      repeat (4) cyc(1'b1, 1'b1);
   endtask

   task automatic test_reset();
      obs_t got;
      obs_t want;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.aeqb     = 1'b1;
      bus.clear    = 1'b0;
      @(posedge clk);
      #1;
      got  = sample();
      want = ex(0, 0, 0, 0, 0);
      if (got !== want) begin
         $display("FAIL reset_held: got %s want %s", fmt(got), fmt(want));
         miscompares++;
      end
      vectors++;
      rst = 1'b0;
      cyc(1'b0, 1'b1);
      got = sample();
      if (got !== want) begin
         $display("FAIL reset_idle: got %s want %s", fmt(got), fmt(want));
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_lock();
      obs_t got;
      obs_t want;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1);
         got  = sample();
         want = ex(i >= 3, i == 3, 0, i + 1, 0);
         if (got !== want) begin
            $display("FAIL lock[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_broken_run();
      obs_t got;
      obs_t want;
      bit   pat [8];
      int   run_e [8];
      pat   = '{1, 1, 1, 0, 1, 1, 1, 1};
      run_e = '{1, 2, 3, 0, 1, 2, 3, 4};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, pat[i]);
         got  = sample();
         want = ex(i == 7, i == 7, 0, run_e[i], 0);
         if (got !== want) begin
            $display("FAIL broken_run[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_glitch();
      obs_t got;
      obs_t want;
      bit   a_t [3];
      int   run_e [3];
      a_t   = '{0, 1, 1};
      run_e = '{0, 1, 2};
      do_reset();
      lock_up();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, a_t[i]);
         got  = sample();
         want = ex(1, 0, 0, run_e[i], 1);
         if (got !== want) begin
            $display("FAIL glitch[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_unlock();
      obs_t got;
      obs_t want;
      bit   v_t [4];
      bit   a_t [4];
      bit   l_e [4];
      bit   up_e [4];
      int   run_e [4];
      int   err_e [4];
      v_t   = '{1, 1, 0, 1};
      a_t   = '{0, 0, 0, 1};
      l_e   = '{1, 0, 0, 0};
      up_e  = '{0, 1, 0, 0};
      run_e = '{0, 0, 0, 1};
      err_e = '{1, 2, 2, 2};
      do_reset();
      lock_up();
      for (int i = 0; i < 4; i++) begin
         cyc(v_t[i], a_t[i]);
         got  = sample();
         want = ex(l_e[i], 0, up_e[i], run_e[i], err_e[i]);
         if (got !== want) begin
            $display("FAIL unlock[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_gaps();
      obs_t got;
      obs_t want;
      bit   v_t [9];
      bit   a_t [9];
      int   run_e [9];
      v_t   = '{1, 0, 1, 0, 0, 1, 0, 1, 0};
      a_t   = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
      run_e = '{1, 1, 2, 2, 2, 3, 3, 4, 4};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cyc(v_t[i], a_t[i]);
         got  = sample();
         want = ex(i >= 7, i == 7, 0, run_e[i], 0);
         if (got !== want) begin
            $display("FAIL gaps[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_clear_hold();
      obs_t got;
      obs_t want;
      bit   c_t [4];
      bit   a_t [4];
      bit   l_e [4];
      int   run_e [4];
      int   err_e [4];
      c_t   = '{0, 1, 0, 0};
      a_t   = '{0, 0, 1, 0};
      l_e   = '{1, 0, 0, 0};
      run_e = '{0, 0, 1, 0};
      err_e = '{1, 0, 0, 0};
      do_reset();
      lock_up();
      for (int i = 0; i < 4; i++) begin
         bus.clear = c_t[i];
         cyc(1'b1, a_t[i]);
         got  = sample();
         want = ex(l_e[i], 0, 0, run_e[i], err_e[i]);
         if (got !== want) begin
            $display("FAIL clear_hold[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
      bus.clear = 1'b0;
   endtask

   task automatic test_async_reset();
      obs_t got;
      obs_t want;
      do_reset();
      lock_up();
      cyc(1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      got  = sample();
      want = ex(0, 0, 0, 0, 0);
      if (got !== want) begin
         $display("FAIL async_reset: got %s want %s", fmt(got), fmt(want));
         miscompares++;
      end
      vectors++;
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 1'b1);
      got  = sample();
      want = ex(0, 0, 0, 1, 0);
      if (got !== want) begin
         $display("FAIL async_reset_resume: got %s want %s", fmt(got), fmt(want));
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_saturation();
      obs_t got;
      obs_t want;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         cyc(1'b1, 1'b1);
         got  = sample();
         want = ex(i >= 3, i == 3, 0, (i + 1 > 255) ? 255 : i + 1, 0);
         if (got !== want) begin
            $display("FAIL saturation[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_three_miss();
      obs_t got;
      obs_t want;
      bit   l_e [3];
      bit   up_e [3];
      int   err_e [3];
      l_e   = '{1, 0, 0};
      up_e  = '{0, 1, 0};
      err_e = '{1, 2, 2};
      do_reset();
      lock_up();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0);
         got  = sample();
         want = ex(l_e[i], 0, up_e[i], 0, err_e[i]);
         if (got !== want) begin
            $display("FAIL three_miss[%0d]: got %s want %s", i, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_back_to_back();
      obs_t got;
      obs_t want;
      int   e;
      do_reset();
      lock_up();
      for (int k = 0; k < 260; k++) begin
         e = (k + 1 > 255) ? 255 : k + 1;
         cyc(1'b1, 1'b0);
         got  = sample();
         want = ex(1, 0, 0, 0, e);
         if (got !== want) begin
            $display("FAIL b2b_miss[%0d]: got %s want %s", k, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
         cyc(1'b1, 1'b1);
         got  = sample();
         want = ex(1, 0, 0, 1, e);
         if (got !== want) begin
            $display("FAIL b2b_hit[%0d]: got %s want %s", k, fmt(got), fmt(want));
            miscompares++;
         end
         vectors++;
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.aeqb     = 1'b0;
      bus.clear    = 1'b0;
      #2;
      test_reset();
      test_lock();
      test_broken_run();
      test_glitch();
      test_unlock();
      test_gaps();
      test_clear_hold();
      test_async_reset();
      test_saturation();
      test_three_miss();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/eq_lock_detector.md
# eq_lock_detector

Sequential consumer of the 2-bit equality comparator's `aeqb` flag. Samples the flag on qualified cycles and declares lock after `LOCK_CNT` consecutive matches. Drops lock after `UNLOCK_CNT` consecutive mismatches. Reports the current match run length and a mismatch-while-locked error count. Sits directly downstream of the comparator, whose operands are driven by the upstream data path.

## Interface
- `LOCK_CNT`, default 4: consecutive valid matches needed to lock; legal range 1..2^CW-1.
- `UNLOCK_CNT`, default 2: consecutive valid mismatches needed to drop lock; legal range 1..2^CW-1.
- `CW`, default 8: width of the counters and count outputs.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value.
- `in_valid`  in  1  qualifies `aeqb` this cycle.
- `aeqb`  in  1  equality flag from the comparator; 1 = operands equal.
- `clear`  in  1  synchronous clear; same effect as reset, taken at the next edge.
- `locked`  out  1  high in LOCKED and HOLD states.
- `lock_pulse`  out  1  one-cycle pulse on SEARCH→LOCKED.
- `unlock_pulse`  out  1  one-cycle pulse on HOLD/LOCKED→SEARCH.
- `run_len`  out  CW  current consecutive-match count, saturating at 2^CW-1.
- `err_cnt`  out  CW  valid mismatches taken while locked, saturating at 2^CW-1.

## Operation
- States: SEARCH (reset state), LOCKED, HOLD. Internal miss counter `miss` (CW bits).
- Every output is registered. Reset/clear values: state=SEARCH, `locked`=0, both pulses 0, `run_len`=0, `err_cnt`=0, `miss`=0.
- `in_valid`=0: no state or counter change; pulses deassert.
- SEARCH, valid match: `run_len`++.
  - If the new value equals `LOCK_CNT`: go to LOCKED, `lock_pulse`=1.
- SEARCH, valid mismatch: `run_len`=0; stay in SEARCH; `err_cnt` unchanged.
- LOCKED, valid match: `run_len` saturating ++.
- LOCKED, valid mismatch: `run_len`=0, `err_cnt`++, `miss`=1.
  - If `UNLOCK_CNT`=1: go to SEARCH, `unlock_pulse`=1.
  - Otherwise: go to HOLD.
- HOLD, valid match: `miss`=0, `run_len`=1, return to LOCKED, no pulse.
- HOLD, valid mismatch: `err_cnt`++, `miss`++.
  - If `miss` reaches `UNLOCK_CNT`: go to SEARCH, `miss`=0, `unlock_pulse`=1.
- `LOCK_CNT`=1: the first valid match locks.
- Counter arithmetic:
  - `run_len` and `err_cnt` saturate; they never wrap.
  - The `LOCK_CNT` compare uses the unsaturated increment, so the legal parameter range keeps it reachable.
- Priority: `reset` > `clear` > `in_valid`. Clear during LOCKED or HOLD drops `locked` without an `unlock_pulse`.

## Timing
- Latency: a sample presented with `in_valid` at edge N is reflected on all outputs after edge N (one-cycle registered).
- `locked` and `lock_pulse` rise on the same edge. `locked` falls on the same edge that `unlock_pulse` rises.
- Pulses are exactly one cycle wide, even if `in_valid` stays high.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- Async `reset` mid-operation clears outputs immediately, independent of `clk`. Deassertion is assumed synchronous to `clk` by the surrounding design.

## Configuration
- Macro: `EQ_LOCK_ERRCNT_EN`.
- Defined: `err_cnt` counter present and behaves as above.
- Undefined: the counter is not built, `err_cnt` is tied to 0, and lock/unlock behaviour is otherwise identical.

## Test plan
All scenarios use `LOCK_CNT`=4, `UNLOCK_CNT`=2, `CW`=8, with `EQ_LOCK_ERRCNT_EN` defined unless stated.

- Lock: reset, then 4 valid matches → `run_len` 1,2,3,4; `locked`=1 and `lock_pulse`=1 for exactly one cycle after the 4th edge.
- Broken run: 3 matches, 1 mismatch, 4 matches → `run_len` goes to 0 after the mismatch; lock declared only after the 8th sample; `err_cnt`=0.
- Single glitch while locked: lock, then 1 mismatch, then 1 match → `locked` stays 1; `err_cnt`=1; `run_len`=1; no `unlock_pulse`.
- Unlock: lock, then 2 mismatches → `unlock_pulse` one cycle and `locked`=0 after the 2nd; `err_cnt`=2; `run_len`=0.
- Gaps and clears:
  - Matches interleaved with `in_valid`=0 cycles → lock after the 4th valid match only.
  - `clear` asserted while in HOLD → all outputs 0 next cycle, no pulse.
  - Async `reset` mid-cycle → outputs 0 before the next edge.
- Saturation and macro off:
  - 300 consecutive matches → `run_len` holds at 255.
  - Rebuild without `EQ_LOCK_ERRCNT_EN`, then lock followed by 3 mismatches → `err_cnt`=0, unlock behaviour unchanged.
